sd_sektor_cache_leser: RTL and testbench

Word-oriented read front-end for the SPI SD-card byte controller. Converts word-address read requests into full-sector reads and keeps the last fetched sector in a local buffer, so later reads to the same sector complete without card traffic. Returns the requested word as soon as its bytes arrive, before the rest of the sector has streamed in. Sits between the CPU/memory bus and an externally instantiated sd_controller.

---
 rtl/sd_leser_pkg.sv | 25 ++
 rtl/sd_sektor_puffer.sv | 37 +++
 rtl/sd_sektor_cache_leser.sv | 166 ++++++++++++++++
 tb/tb_sd_sektor_cache_leser.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_leser_pkg.sv
// Shared constants for the sector-cached SD word reader: FSM encoding,
// sector geometry and the big-endian byte-lane mapping.
package sd_leser_pkg;

  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_HIT     = 3'd2;
  localparam logic [2:0] ST_START   = 3'd3;
  localparam logic [2:0] ST_FUELLEN = 3'd4;
  localparam logic [2:0] ST_FERTIG  = 3'd5;

  localparam int SEKTOR_BYTES  = 512;
  localparam int BYTE_IDX_BITS = 9;

  // Width of the word offset inside one sector.
  function automatic int offset_bits(input int wort_bytes);
    return $clog2(SEKTOR_BYTES / wort_bytes);
  endfunction

  // The k-th streamed byte of a word lands in the most significant lane first.
  function automatic int lane_lsb(input int k, input int wort_bytes);
    return 8 * (wort_bytes - 1 - k);
  endfunction

endpackage

// File: rtl/sd_sektor_puffer.sv
// One-sector buffer: WORT_BYTES byte-wide banks written a byte at a time,
// read back as a whole registered word per row.
module sd_sektor_puffer
  import sd_leser_pkg::*;
#(
  parameter int WORT_BYTES = 4,
  localparam int ROW_BITS = offset_bits(WORT_BYTES)
) (
  input  logic                      clock,
  input  logic                      we,
  input  logic [BYTE_IDX_BITS-1:0]  wr_idx,
  input  logic [7:0]                wr_data,
  input  logic [ROW_BITS-1:0]       rd_row,
  output logic [8*WORT_BYTES-1:0]   rd_data
);

  localparam int TIEFE = SEKTOR_BYTES / WORT_BYTES;

  logic [ROW_BITS-1:0] wr_row;
  assign wr_row = wr_idx[BYTE_IDX_BITS-1 -: ROW_BITS];

  for (genvar b = 0; b < WORT_BYTES; b++) begin : g_bank
    logic [7:0] mem [TIEFE];
    logic [7:0] lane_q;
    logic       bank_sel;

    assign bank_sel = ((wr_idx % 9'(WORT_BYTES)) == 9'(b));

    always_ff @(posedge clock) begin
      if (we && bank_sel) mem[wr_row] <= wr_data;
      lane_q <= mem[rd_row];
    end

    assign rd_data[lane_lsb(b, WORT_BYTES) +: 8] = lane_q;
  end

endmodule

// File: rtl/sd_sektor_cache_leser.sv
// Word read front-end for the SPI SD byte controller; caches the last sector
// and returns the requested word as soon as its bytes have streamed in.
module sd_sektor_cache_leser
  import sd_leser_pkg::*;
#(
  parameter int WORT_BYTES     = 4,
  parameter int TIMEOUT_ZYKLEN = 1000000
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [31:0]             Adresse,
  input  logic                    Lesen,
  input  logic                    Invalidieren,
  output logic [8*WORT_BYTES-1:0] Daten,
  output logic                    Fertig,
  output logic                    Treffer,
  output logic                    Busy,
  output logic                    Fehler,
  output logic [2:0]              zustand,
  output logic                    sd_rd,
  output logic [31:0]             sd_address,
  input  logic [7:0]              sd_dout,
  input  logic                    sd_byte_available,
  input  logic                    sd_ready
);

  localparam int OFS_BITS = offset_bits(WORT_BYTES);
  localparam int TAG_BITS = 32 - OFS_BITS;
  localparam int WD_BITS  = $clog2(TIMEOUT_ZYKLEN + 1);
  localparam int DW       = 8 * WORT_BYTES;

  logic [2:0]               state, state_next;
  logic                     valid;
  logic [TAG_BITS-1:0]      tag;
  logic [OFS_BITS-1:0]      offset;
  logic [BYTE_IDX_BITS-1:0] zaehler;
  logic [WD_BITS-1:0]       watchdog;
  logic                     hit_phase;
  logic [DW-1:0]            wort, wort_next, puffer_wort;

  logic [TAG_BITS-1:0]      adr_tag;
  logic [OFS_BITS-1:0]      adr_ofs;
  logic [BYTE_IDX_BITS-1:0] last_idx;
  logic treffer_req, timeout, byte_wr, wort_komplett, sektor_ende;

  assign adr_tag = Adresse[31:OFS_BITS];
  assign adr_ofs = Adresse[OFS_BITS-1:0];
  assign last_idx = 9'(offset) * 9'(WORT_BYTES) + 9'(WORT_BYTES - 1);

  // Invalidieren in the same cycle wins over a matching tag.
  assign treffer_req   = Lesen && valid && !Invalidieren && (adr_tag == tag);
  assign timeout       = ((state == ST_START) || (state == ST_FUELLEN)) && !sd_byte_available
                         && (watchdog == WD_BITS'(TIMEOUT_ZYKLEN - 1));
  assign byte_wr       = (state == ST_FUELLEN) && sd_byte_available;
  assign wort_komplett = byte_wr && (zaehler == last_idx);
  assign sektor_ende   = byte_wr && (zaehler == 9'(SEKTOR_BYTES - 1));
  assign sd_address    = 32'({tag, 9'b0});

  sd_sektor_puffer #(.WORT_BYTES(WORT_BYTES)) u_puffer (
    .clock   (Clock),
    .we      (byte_wr),
    .wr_idx  (zaehler),
    .wr_data (sd_dout),
    .rd_row  (offset),
    .rd_data (puffer_wort)
  );

  // Bypass word: the requested word is assembled while it streams past.
  always_comb begin
    wort_next = wort;
    wort_next[lane_lsb(int'(zaehler % 9'(WORT_BYTES)), WORT_BYTES) +: 8] = sd_dout;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:    if (sd_ready) state_next = ST_IDLE;
      ST_IDLE:    if (Lesen) state_next = treffer_req ? ST_HIT : ST_START;
      ST_HIT:     if (hit_phase) state_next = ST_IDLE;
      ST_START:   if (timeout) state_next = ST_INIT;
                  else if (sd_ready) state_next = ST_FUELLEN;
      ST_FUELLEN: if (timeout) state_next = ST_INIT;
                  else if (sektor_ende) state_next = ST_FERTIG;
      ST_FERTIG:  if (sd_ready) state_next = ST_IDLE;
      default:    state_next = ST_INIT;
    endcase
  end

  always_comb begin
    Busy    = (state != ST_IDLE);
    zustand = state;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Daten     <= '0;
      Fertig    <= 1'b0;
      Treffer   <= 1'b0;
      Fehler    <= 1'b0;
      sd_rd     <= 1'b0;
      valid     <= 1'b0;
      tag       <= '0;
      offset    <= '0;
      zaehler   <= '0;
      watchdog  <= '0;
      hit_phase <= 1'b0;
      wort      <= '0;
    end else begin
      Fertig    <= 1'b0;
      Treffer   <= 1'b0;
      Fehler    <= 1'b0;
      hit_phase <= (state == ST_HIT) && !hit_phase;

      if (((state == ST_START) || (state == ST_FUELLEN)) && !sd_byte_available)
        watchdog <= watchdog + 1'b1;
      else
        watchdog <= '0;

      if (state == ST_IDLE) begin
        if (Invalidieren) valid <= 1'b0;
        if (Lesen) begin
          offset <= adr_ofs;
          if (!treffer_req) begin
            tag   <= adr_tag;
            valid <= 1'b0;
          end
        end
      end

      if ((state == ST_HIT) && hit_phase) begin
        Daten   <= puffer_wort;
        Fertig  <= 1'b1;
        Treffer <= 1'b1;
      end

      if ((state == ST_START) && sd_ready && !timeout) sd_rd <= 1'b1;

      if (byte_wr) begin
        zaehler <= zaehler + 1'b1;
        sd_rd   <= 1'b0;
        wort    <= wort_next;
        if (wort_komplett) begin
          Daten  <= wort_next;
          Fertig <= 1'b1;
        end
        if (sektor_ende) begin
          valid   <= 1'b1;
          zaehler <= '0;
        end
      end

      if (timeout) begin
        Fehler  <= 1'b1;
        valid   <= 1'b0;
        sd_rd   <= 1'b0;
        zaehler <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sd_sektor_cache_leser.sv
// Randomized bench for sd_sektor_cache_leser with a behavioural SD card and a
// sector-cache reference model feeding an expected-result queue.
module tb_sd_sektor_cache_leser;

  localparam int TIMEOUT = 50;

  typedef struct packed {
    logic [31:0] word;
    logic        hit;
    logic [31:0] accept;
    logic [8:0]  last_idx;
  } exp_t;

  logic        clock, reset;
  logic [31:0] adresse;
  logic        lesen, invalidieren;
  logic [31:0] daten;
  logic        fertig, treffer, busy, fehler;
  logic [2:0]  zustand;
  logic        sd_rd;
  logic [31:0] sd_address;
  logic [7:0]  sd_dout;
  logic        sd_byte_available, sd_ready;

  sd_sektor_cache_leser #(.WORT_BYTES(4), .TIMEOUT_ZYKLEN(TIMEOUT)) dut (
    .Clock(clock), .Reset(reset), .Adresse(adresse), .Lesen(lesen),
    .Invalidieren(invalidieren), .Daten(daten), .Fertig(fertig), .Treffer(treffer),
    .Busy(busy), .Fehler(fehler), .zustand(zustand), .sd_rd(sd_rd),
    .sd_address(sd_address), .sd_dout(sd_dout), .sd_byte_available(sd_byte_available),
    .sd_ready(sd_ready)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int   n_cmp = 0, n_err = 0;
  int   n_fertig = 0, n_fehler = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic m_valid = 1'b0;
  int   m_tag = 0;
  int   m_timeouts = 0;

  // ---------------- card model state ----------------
  logic        card_enable = 1'b0;
  logic        card_active = 1'b0;
  int          card_idx = 0, card_sector = 0, gap = 0;
  int          stall_limit = 512;
  int          rd_starts = 0;
  int          abort_req = 0, abort_seen = 0;
  logic        rd_drop_pending = 1'b0;
  logic [31:0] card_addr = '0;
  int          byte_edge [512];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  function automatic logic [7:0] card_byte(input int s, input int i);
    return 8'(i + 37 * s - 37);
  endfunction

  function automatic logic [31:0] model_word(input int s, input int o);
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++) w = {w[23:0], card_byte(s, o * 4 + k)};
    return w;
  endfunction

  // ---------------- SD card model ----------------
  initial begin
    sd_ready = 1'b0;
    sd_dout = '0;
    sd_byte_available = 1'b0;
    forever begin
      @(negedge clock);
      sd_byte_available = 1'b0;
      if (rd_drop_pending) begin
        check_eq("sd_rd_drop", sd_rd, 0);
        rd_drop_pending = 1'b0;
      end
      if (abort_req != abort_seen) begin
        abort_seen = abort_req;
        card_active = 1'b0;
      end
      if (!card_active) begin
        if (sd_rd && sd_ready) begin
          card_active = 1'b1;
          card_addr = sd_address;
          card_sector = int'(sd_address >> 9);
          card_idx = 0;
          rd_starts++;
          sd_ready = 1'b0;
          gap = $urandom_range(0, 3);
        end else begin
          sd_ready = card_enable;
        end
      end else if (gap > 0) begin
        gap--;
      end else if (card_idx < stall_limit) begin
        sd_dout = card_byte(card_sector, card_idx);
        sd_byte_available = 1'b1;
        byte_edge[card_idx] = cyc + 1;
        if (card_idx == 0) rd_drop_pending = 1'b1;
        card_idx++;
        gap = $urandom_range(0, 2);
        if (card_idx == 512) card_active = 1'b0;
      end
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (fertig) begin
        n_fertig++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_fertig", fertig, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("daten", daten, mon_e.word);
          check_eq("treffer", treffer, mon_e.hit);
          check_eq("busy_at_fertig", busy, !mon_e.hit);
          if (mon_e.hit) check_eq("hit_latency", cyc, mon_e.accept + 2);
          else           check_eq("fill_latency", cyc, byte_edge[mon_e.last_idx]);
        end
      end else if (treffer) begin
        check_eq("treffer_without_fertig", treffer, 0);
      end
      if (fehler) n_fehler++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (busy !== 1'b0) begin
      check_eq("idle_timeout", busy, 0);
      finish_run();
    end
  endtask

  task automatic do_read(input int s, input int o, input logic inv);
    exp_t e;
    int   rd0;
    logic hit;
    wait_idle();
    if (inv) m_valid = 1'b0;
    hit = m_valid && (m_tag == s);
    e.word = model_word(s, o);
    e.hit = hit;
    e.accept = 32'(cyc + 1);
    e.last_idx = 9'(o * 4 + 3);
    exp_q.push_back(e);
    rd0 = rd_starts;
    adresse = 32'((s << 7) | o);
    lesen = 1'b1;
    invalidieren = inv;
    @(negedge clock);
    lesen = 1'b0;
    invalidieren = 1'b0;
    adresse = $urandom;
    if (!hit) begin
      m_valid = 1'b1;
      m_tag = s;
    end
    wait_idle();
    @(negedge clock);
    check_eq("sd_rd_count", 64'(rd_starts - rd0), hit ? 64'd0 : 64'd1);
    if (!hit) check_eq("sd_address", card_addr, 64'(s) << 9);
    check_eq("exp_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_invalidate();
    wait_idle();
    invalidieren = 1'b1;
    @(negedge clock);
    invalidieren = 1'b0;
    m_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, fcyc, nf0;
    reset = 1'b1;
    adresse = '0;
    lesen = 1'b0;
    invalidieren = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_daten", daten, 0);
    check_eq("rst_fertig", fertig, 0);
    check_eq("rst_treffer", treffer, 0);
    check_eq("rst_fehler", fehler, 0);
    check_eq("rst_sd_rd", sd_rd, 0);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_zustand", zustand, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq("init_busy", busy, 1);
      check_eq("init_zustand", zustand, 0);
      check_eq("init_fertig", fertig, 0);
    end
    card_enable = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 10) begin
      @(negedge clock);
      n++;
    end
    check_eq("init_to_idle_busy", busy, 0);
    check_eq("idle_zustand", zustand, 1);

    do_read(1, 5, 1'b0);
    do_read(1, 127, 1'b0);
    do_read(1, 5, 1'b1);
    do_read(0, 127, 1'b0);
    do_read(2, 0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      int   s, o;
      logic inv;
      if (m_valid && $urandom_range(0, 1) == 1) s = m_tag;
      else s = $urandom_range(0, 3);
      o = $urandom_range(0, 127);
      inv = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) do_invalidate();
      do_read(s, o, inv);
    end

    // fill stalls after three bytes
    wait_idle();
    stall_limit = 3;
    nf0 = n_fertig;
    adresse = 32'((5 << 7) | 100);
    lesen = 1'b1;
    @(negedge clock);
    lesen = 1'b0;
    m_valid = 1'b0;
    n = 0;
    while (fehler !== 1'b1 && n < 500) begin
      @(negedge clock);
      n++;
    end
    check_eq("timeout_seen", fehler, 1);
    fcyc = cyc;
    m_timeouts++;
    check_eq("timeout_latency", 64'(fcyc - byte_edge[2]), TIMEOUT);
    check_eq("timeout_zustand", zustand, 0);
    check_eq("timeout_sd_rd", sd_rd, 0);
    check_eq("timeout_no_fertig", 64'(n_fertig - nf0), 0);
    @(negedge clock);
    check_eq("fehler_pulse", fehler, 0);
    stall_limit = 512;
    abort_req++;
    do_read(5, 100, 1'b0);

    // reset in the middle of a fill
    wait_idle();
    adresse = 32'((6 << 7) | 120);
    lesen = 1'b1;
    @(negedge clock);
    lesen = 1'b0;
    n = 0;
    while (card_idx < 100 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    reset = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 1);
    check_eq("midrst_zustand", zustand, 0);
    check_eq("midrst_sd_rd", sd_rd, 0);
    check_eq("midrst_fertig", fertig, 0);
    check_eq("midrst_daten", daten, 0);
    abort_req++;
    m_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    do_read(6, 120, 1'b0);
    do_read(6, 0, 1'b0);

    check_eq("fehler_count", n_fehler, m_timeouts);
    finish_run();
  end

endmodule
